// File: rtl/bellek_sinayici_if.sv
// Request/response bus between the memory-test engine (master) and the memory
// or cache under test (slave). Both directions use a valid/ready handshake.
interface bellek_sinayici_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] istek_adres;
    logic [DATA_W-1:0] istek_veri;
    logic              istek_gecerli;
    logic              istek_yaz;
    logic              istek_hazir;
    logic [DATA_W-1:0] cevap_veri;
    logic              cevap_gecerli;
    logic              cevap_hazir;

    modport master (
        output istek_adres, istek_veri, istek_gecerli, istek_yaz, cevap_hazir,
        input  istek_hazir, cevap_veri, cevap_gecerli
    );

    modport slave (
        input  istek_adres, istek_veri, istek_gecerli, istek_yaz, cevap_hazir,
        output istek_hazir, cevap_veri, cevap_gecerli
    );
endinterface

// File: rtl/bellek_sinayici.sv
// bellek_sinayici: memory-test engine. Writes data(i) = (PATTERN_BASE + i) & DATA_MASK
// to TEST_LEN addresses spaced STRIDE apart, then reads each address back and
// compares, counting mismatches and latching the first failing address.
// Optional watchdog: define BELLEK_SINAYICI_ZAMANASIMI_EN to add zamanasimi_o and
// end the test in BITTI after TIMEOUT cycles without a handshake.
//
// state     | meaning
// BOSTA     | idle after reset, waiting for basla_i
// YAZ       | streaming writes, a new one on every accepted request
// OKU_ISTEK | presenting a read request
// OKU_BEKLE | waiting for the single outstanding read response
// BITTI     | results held; basla_i restarts the test
module bellek_sinayici #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned TEST_LEN     = 16384,
    parameter int unsigned STRIDE       = 1,
    parameter logic [31:0] PATTERN_BASE = 32'hABCD_0000,
    parameter logic [31:0] DATA_MASK    = 32'hFFFF_FFFC,
    parameter int unsigned TIMEOUT      = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              basla_i,
    bellek_sinayici_if.master bus,
    output logic              bitti_o,
    output logic              basarili_o,
    output logic [31:0]       hata_sayisi_o,
    output logic [ADDR_W-1:0] ilk_hata_adres_o
`ifdef BELLEK_SINAYICI_ZAMANASIMI_EN
    ,
    output logic              zamanasimi_o
`endif
);
    localparam int unsigned       IDX_W     = $clog2(TEST_LEN) + 1;
    localparam logic [IDX_W-1:0]  SON_IDX   = IDX_W'(TEST_LEN - 1);
    localparam logic [DATA_W-1:0] DESEN_ILK = DATA_W'(PATTERN_BASE);
    localparam logic [DATA_W-1:0] MASKE     = DATA_W'(DATA_MASK);

    typedef enum logic [2:0] {BOSTA, YAZ, OKU_ISTEK, OKU_BEKLE, BITTI} durum_t;

    durum_t            durum_q;
    logic [IDX_W-1:0]  idx_q;
    logic [ADDR_W-1:0] adres_q, adres_d;
    logic [DATA_W-1:0] desen_q, desen_d;
    logic [DATA_W-1:0] veri_q;
    logic              gecerli_q, yaz_q, cevap_hazir_q;
    logic              bitti_q, basarili_q;
    logic [31:0]       hata_q, hata_d;
    logic [ADDR_W-1:0] ilk_q;
    logic              hata_var_q;
    logic              uyusmaz;
    logic              son_idx;
    logic              basla_kabul;

    // Address and pattern advance incrementally, so no multiplier is needed for i*STRIDE.
    always_comb begin
        adres_d = adres_q + ADDR_W'(STRIDE);
        desen_d = desen_q + DATA_W'(1);
        hata_d  = (hata_q == 32'hFFFF_FFFF) ? hata_q : hata_q + 32'd1;
        uyusmaz = (bus.cevap_veri != (desen_q & MASKE));
    end

    assign son_idx     = (idx_q == SON_IDX);
    assign basla_kabul = basla_i && (durum_q == BOSTA || durum_q == BITTI);

`ifdef BELLEK_SINAYICI_ZAMANASIMI_EN
    localparam int unsigned     WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_YUK = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] wd_q;
    logic            zaman_q;
    logic            el_sikisma;

    assign el_sikisma = ((durum_q == YAZ || durum_q == OKU_ISTEK) && bus.istek_hazir) ||
                        (durum_q == OKU_BEKLE && bus.cevap_gecerli);
    assign zamanasimi_o = zaman_q;
`endif

    // Test sequencer: all bus-facing and result outputs are registered here.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            durum_q       <= BOSTA;
            idx_q         <= '0;
            adres_q       <= '0;
            desen_q       <= '0;
            veri_q        <= '0;
            gecerli_q     <= 1'b0;
            yaz_q         <= 1'b0;
            cevap_hazir_q <= 1'b0;
            bitti_q       <= 1'b0;
            basarili_q    <= 1'b0;
            hata_q        <= '0;
            ilk_q         <= '0;
            hata_var_q    <= 1'b0;
`ifdef BELLEK_SINAYICI_ZAMANASIMI_EN
            wd_q          <= '0;
            zaman_q       <= 1'b0;
`endif
        end else begin
            case (durum_q)
                BOSTA, BITTI: begin
                    if (basla_i) begin
                        durum_q       <= YAZ;
                        idx_q         <= '0;
                        adres_q       <= '0;
                        desen_q       <= DESEN_ILK;
                        veri_q        <= DESEN_ILK & MASKE;
                        gecerli_q     <= 1'b1;
                        yaz_q         <= 1'b1;
                        cevap_hazir_q <= 1'b0;
                        bitti_q       <= 1'b0;
                        basarili_q    <= 1'b0;
                        hata_q        <= '0;
                        ilk_q         <= '0;
                        hata_var_q    <= 1'b0;
                    end
                end
                YAZ: begin
                    if (bus.istek_hazir) begin
                        if (son_idx) begin
                            durum_q <= OKU_ISTEK;
                            idx_q   <= '0;
                            adres_q <= '0;
                            desen_q <= DESEN_ILK;
                            veri_q  <= '0;
                            yaz_q   <= 1'b0;
                        end else begin
                            idx_q   <= idx_q + IDX_W'(1);
                            adres_q <= adres_d;
                            desen_q <= desen_d;
                            veri_q  <= desen_d & MASKE;
                        end
                    end
                end
                OKU_ISTEK: begin
                    if (bus.istek_hazir) begin
                        durum_q       <= OKU_BEKLE;
                        gecerli_q     <= 1'b0;
                        cevap_hazir_q <= 1'b1;
                    end
                end
                OKU_BEKLE: begin
                    if (bus.cevap_gecerli) begin
                        cevap_hazir_q <= 1'b0;
                        if (uyusmaz) begin
                            hata_q <= hata_d;
                            if (!hata_var_q) begin
                                hata_var_q <= 1'b1;
                                ilk_q      <= adres_q;
                            end
                        end
                        if (son_idx) begin
                            durum_q    <= BITTI;
                            bitti_q    <= 1'b1;
                            basarili_q <= (hata_q == 32'd0) && !uyusmaz;
                        end else begin
                            durum_q   <= OKU_ISTEK;
                            gecerli_q <= 1'b1;
                            idx_q     <= idx_q + IDX_W'(1);
                            adres_q   <= adres_d;
                            desen_q   <= desen_d;
                        end
                    end
                end
                default: durum_q <= BOSTA;
            endcase
`ifdef BELLEK_SINAYICI_ZAMANASIMI_EN
            // Watchdog down-counter: reloaded on every handshake, expiry overrides the step above.
            if (durum_q == YAZ || durum_q == OKU_ISTEK || durum_q == OKU_BEKLE) begin
                if (el_sikisma) begin
                    wd_q <= WD_YUK;
                end else if (wd_q == '0) begin
                    durum_q       <= BITTI;
                    bitti_q       <= 1'b1;
                    basarili_q    <= 1'b0;
                    zaman_q       <= 1'b1;
                    gecerli_q     <= 1'b0;
                    yaz_q         <= 1'b0;
                    veri_q        <= '0;
                    cevap_hazir_q <= 1'b0;
                end else begin
                    wd_q <= wd_q - WD_W'(1);
                end
            end else if (basla_kabul) begin
                wd_q    <= WD_YUK;
                zaman_q <= 1'b0;
            end
`endif
        end
    end

    assign bus.istek_adres   = adres_q;
    assign bus.istek_veri    = veri_q;
    assign bus.istek_gecerli = gecerli_q;
    assign bus.istek_yaz     = yaz_q;
    assign bus.cevap_hazir   = cevap_hazir_q;
    assign bitti_o           = bitti_q;
    assign basarili_o        = basarili_q;
    assign hata_sayisi_o     = hata_q;
    assign ilk_hata_adres_o  = ilk_q;
endmodule

// File: tb/tb_bellek_sinayici.sv
// Bench for bellek_sinayici: two engines (aliasing stride-4 run and a plain
// stride-1 run) against behavioural memories with random stalls and delays.
module tb_bellek_sinayici;
    localparam int AW   = 8;
    localparam int DW   = 32;
    localparam int LEN0 = 80;
    localparam int STR0 = 4;
    localparam int LEN1 = 64;
    localparam int STR1 = 1;
    localparam logic [31:0] BASE = 32'hABCD_0000;
    localparam logic [31:0] MASK = 32'hFFFF_FFFC;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          basla    [2];
    logic          bitti    [2];
    logic          basarili [2];
    logic [31:0]   hata     [2];
    logic [AW-1:0] ilk      [2];
`ifdef BELLEK_SINAYICI_ZAMANASIMI_EN
    logic          zaman    [2];
`endif
    logic          hz [2];
    logic          rv [2];
    logic [DW-1:0] rd [2];
    logic          gv [2];
    logic          yz [2];
    logic          ch [2];
    logic [AW-1:0] ad [2];
    logic [DW-1:0] vd [2];

    bellek_sinayici_if #(.ADDR_W(AW), .DATA_W(DW)) bif0 ();
    bellek_sinayici_if #(.ADDR_W(AW), .DATA_W(DW)) bif1 ();

    assign bif0.istek_hazir   = hz[0];
    assign bif0.cevap_gecerli = rv[0];
    assign bif0.cevap_veri    = rd[0];
    assign bif1.istek_hazir   = hz[1];
    assign bif1.cevap_gecerli = rv[1];
    assign bif1.cevap_veri    = rd[1];
    assign gv[0] = bif0.istek_gecerli;
    assign yz[0] = bif0.istek_yaz;
    assign ch[0] = bif0.cevap_hazir;
    assign ad[0] = bif0.istek_adres;
    assign vd[0] = bif0.istek_veri;
    assign gv[1] = bif1.istek_gecerli;
    assign yz[1] = bif1.istek_yaz;
    assign ch[1] = bif1.cevap_hazir;
    assign ad[1] = bif1.istek_adres;
    assign vd[1] = bif1.istek_veri;

    bellek_sinayici #(.ADDR_W(AW), .DATA_W(DW), .TEST_LEN(LEN0), .STRIDE(STR0)) dut0 (
        .clk_i(clk), .rst_i(rst), .basla_i(basla[0]), .bus(bif0),
        .bitti_o(bitti[0]), .basarili_o(basarili[0]),
        .hata_sayisi_o(hata[0]), .ilk_hata_adres_o(ilk[0])
`ifdef BELLEK_SINAYICI_ZAMANASIMI_EN
        , .zamanasimi_o(zaman[0])
`endif
    );

    bellek_sinayici #(.ADDR_W(AW), .DATA_W(DW), .TEST_LEN(LEN1), .STRIDE(STR1)) dut1 (
        .clk_i(clk), .rst_i(rst), .basla_i(basla[1]), .bus(bif1),
        .bitti_o(bitti[1]), .basarili_o(basarili[1]),
        .hata_sayisi_o(hata[1]), .ilk_hata_adres_o(ilk[1])
`ifdef BELLEK_SINAYICI_ZAMANASIMI_EN
        , .zamanasimi_o(zaman[1])
`endif
    );

    int checks = 0;
    int failures = 0;

    // scoreboard FIFOs of expected requests, per engine
    logic [AW-1:0] q_a [2][256];
    logic [DW-1:0] q_d [2][256];
    logic          q_w [2][256];
    int            q_bas [2];
    int            q_son [2];
    int            okunan [2];

    int            exp_hata [2];
    logic [AW-1:0] exp_ilk  [2];
    logic          exp_ok   [2];
    bit            flt_en   [2];
    logic [AW-1:0] flt_a    [2];
    bit            rnd      [2];
    logic [DW-1:0] mem      [2][256];

    function automatic int len_of(input int k);
        return (k == 0) ? LEN0 : LEN1;
    endfunction

    function automatic int str_of(input int k);
        return (k == 0) ? STR0 : STR1;
    endfunction

    task automatic chk(input bit ok, input string nm, input longint act, input longint expv);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, expv, $time);
        end
    endtask

    // Reference: expected request stream plus final results from last-writer-wins memory.
    task automatic push_exp(input int k);
        logic [DW-1:0] model [256];
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] r;
        q_bas[k] = 0;
        q_son[k] = 0;
        okunan[k] = 0;
        for (int i = 0; i < 256; i++) model[i] = '0;
        for (int i = 0; i < len_of(k); i++) begin
            a = AW'(i * str_of(k));
            d = (BASE + 32'(i)) & MASK;
            q_a[k][q_son[k]] = a; q_d[k][q_son[k]] = d; q_w[k][q_son[k]] = 1'b1;
            q_son[k]++;
            model[a] = d;
        end
        exp_hata[k] = 0;
        exp_ilk[k] = '0;
        for (int i = 0; i < len_of(k); i++) begin
            a = AW'(i * str_of(k));
            d = (BASE + 32'(i)) & MASK;
            q_a[k][q_son[k]] = a; q_d[k][q_son[k]] = '0; q_w[k][q_son[k]] = 1'b0;
            q_son[k]++;
            r = model[a];
            if (flt_en[k] && a == flt_a[k]) r = r ^ 32'd1;
            if (r != d) begin
                if (exp_hata[k] == 0) exp_ilk[k] = a;
                exp_hata[k]++;
            end
        end
        exp_ok[k] = (exp_hata[k] == 0);
    endtask

    // Memory slave and monitor: sampled on the falling edge, handshakes resolved one edge later.
    initial begin : monitor
        bit            pend_req [2];
        bit            pend_rsp [2];
        bit            stall    [2];
        bit            bekle    [2];
        int            dly      [2];
        logic [AW-1:0] c_a      [2];
        logic [DW-1:0] c_d      [2];
        logic          c_w      [2];
        logic [AW-1:0] r_a      [2];
        for (int k = 0; k < 2; k++) begin
            pend_req[k] = 0; pend_rsp[k] = 0; stall[k] = 0; bekle[k] = 0; dly[k] = 0;
            hz[k] = 1'b1; rv[k] = 1'b0; rd[k] = '0;
            c_a[k] = '0; c_d[k] = '0; c_w[k] = 1'b0; r_a[k] = '0;
            for (int i = 0; i < 256; i++) mem[k][i] = '0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (rst) begin
                    pend_req[k] = 0; pend_rsp[k] = 0; stall[k] = 0; bekle[k] = 0;
                    rv[k] = 1'b0; hz[k] = 1'b1;
                    continue;
                end
                if (pend_req[k]) begin
                    if (q_bas[k] == q_son[k]) begin
                        chk(1'b0, "unexpected_request", longint'(c_a[k]), 0);
                    end else begin
                        chk(c_a[k] === q_a[k][q_bas[k]] && c_d[k] === q_d[k][q_bas[k]] &&
                            c_w[k] === q_w[k][q_bas[k]],
                            (k == 0) ? "request_dut0" : "request_dut1",
                            longint'({c_w[k], c_a[k], c_d[k]}),
                            longint'({q_w[k][q_bas[k]], q_a[k][q_bas[k]], q_d[k][q_bas[k]]}));
                        q_bas[k]++;
                        if (c_w[k]) begin
                            mem[k][c_a[k]] = c_d[k];
                        end else begin
                            bekle[k] = 1;
                            r_a[k] = c_a[k];
                            dly[k] = rnd[k] ? int'($urandom_range(0, 5)) : 0;
                        end
                    end
                end
                if (pend_rsp[k]) begin
                    rv[k] = 1'b0;
                    okunan[k]++;
                    if (okunan[k] == len_of(k))
                        chk(bitti[k] === 1'b1, "bitti_latency", longint'(bitti[k]), 1);
                end
                if (stall[k])
                    chk(gv[k] === 1'b1 && yz[k] === c_w[k] && ad[k] === c_a[k] && vd[k] === c_d[k],
                        "stall_stable", longint'({gv[k], yz[k], ad[k], vd[k]}),
                        longint'({1'b1, c_w[k], c_a[k], c_d[k]}));
                if (!rv[k]) rd[k] = $urandom();
                if (bekle[k] && !rv[k]) begin
                    if (dly[k] == 0) begin
                        rv[k] = 1'b1;
                        rd[k] = mem[k][r_a[k]] ^ ((flt_en[k] && r_a[k] == flt_a[k]) ? 32'd1 : 32'd0);
                        bekle[k] = 0;
                    end else begin
                        dly[k]--;
                    end
                end
                hz[k] = rnd[k] ? ($urandom_range(0, 9) >= 3) : 1'b1;
                pend_req[k] = gv[k] && hz[k];
                stall[k]    = gv[k] && !hz[k];
                c_a[k] = ad[k]; c_d[k] = vd[k]; c_w[k] = yz[k];
                pend_rsp[k] = rv[k] && ch[k];
            end
        end
    end

    task automatic start(input int k);
        push_exp(k);
        @(negedge clk);
        #1 basla[k] = 1'b1;
        @(negedge clk);
        chk(gv[k] === 1'b1 && yz[k] === 1'b1 && bitti[k] === 1'b0, "start_latency",
            longint'({gv[k], yz[k], bitti[k]}), 3'b110);
        #1 basla[k] = 1'b0;
    endtask

    task automatic wait_bitti(input int k);
        int c = 0;
        while (bitti[k] !== 1'b1 && c < 4000) begin
            @(negedge clk);
            c++;
        end
        chk(c < 4000, "bitti_wait", c, 4000);
    endtask

    task automatic check_res(input int k);
        chk(bitti[k] === 1'b1, "bitti", longint'(bitti[k]), 1);
        chk(basarili[k] === exp_ok[k], "basarili", longint'(basarili[k]), longint'(exp_ok[k]));
        chk(hata[k] === 32'(exp_hata[k]), "hata_sayisi", longint'(hata[k]), exp_hata[k]);
        chk(ilk[k] === exp_ilk[k], "ilk_hata_adres", longint'(ilk[k]), longint'(exp_ilk[k]));
        chk(q_bas[k] == q_son[k], "queue_drained", q_son[k] - q_bas[k], 0);
        chk(gv[k] === 1'b0 && ch[k] === 1'b0, "idle_bus", longint'({gv[k], ch[k]}), 0);
`ifdef BELLEK_SINAYICI_ZAMANASIMI_EN
        chk(zaman[k] === 1'b0, "zamanasimi", longint'(zaman[k]), 0);
`endif
    endtask

    task automatic check_zero();
        for (int k = 0; k < 2; k++) begin
            chk({gv[k], yz[k], ch[k], bitti[k], basarili[k]} === 5'b0, "reset_flags",
                longint'({gv[k], yz[k], ch[k], bitti[k], basarili[k]}), 0);
            chk(ad[k] === '0 && vd[k] === '0 && hata[k] === '0 && ilk[k] === '0, "reset_values",
                longint'({ad[k], vd[k]}) ^ longint'(hata[k]) ^ longint'(ilk[k]), 0);
        end
    endtask

    initial begin : main
        int c;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            basla[k] = 1'b0; rnd[k] = 0; flt_en[k] = 0; flt_a[k] = '0;
            q_bas[k] = 0; q_son[k] = 0; okunan[k] = 0;
        end
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check_zero();
        #2 rst = 1'b0;

        // ideal memory on dut0 (aliasing), random stalls on dut1
        rnd[1] = 1;
        start(0);
        start(1);
        wait_bitti(0);
        wait_bitti(1);
        check_res(0);
        check_res(1);

        // restart from BITTI with a single corrupted address on each memory
        rnd[0] = 1;
        flt_en[0] = 1; flt_a[0] = AW'(4 * $urandom_range(16, 63));
        flt_en[1] = 1; flt_a[1] = AW'($urandom_range(0, 63));
        start(0);
        start(1);
        wait_bitti(0);
        wait_bitti(1);
        check_res(0);
        check_res(1);

        // reset while dut1 waits for a read response
        flt_en[0] = 0; flt_en[1] = 0;
        start(1);
        c = 0;
        while (ch[1] !== 1'b1 && c < 2000) begin
            @(negedge clk);
            c++;
        end
        chk(c < 2000, "reach_oku_bekle", c, 2000);
        #2 rst = 1'b1;
        #1 check_zero();
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        start(0);
        start(1);
        wait_bitti(0);
        wait_bitti(1);
        check_res(0);
        check_res(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : guard
        #3_000_000;
        $display("FAIL global_timeout actual=%0t expected=finish", $time);
        $fatal(1, "simulation time limit");
    end
endmodule

// File: doc/bellek_sinayici.md
Name: bellek_sinayici

Overview:
- Synthesizable, parametrised memory-test engine; drives processor-side request/response port of onbellek (or directly anabellek-style slave).
- Runs write-all then read-back-and-compare over TEST_LEN addresses with configurable stride and data pattern.
- Counts mismatches and reports pass/fail plus first failing address; replaces the hand-written bench stimulus loop, reusable in simulation and on FPGA.

Parameters:
- ADDR_W, 32, request address width
- DATA_W, 32, request/response data width
- TEST_LEN, 16384, number of addresses tested (>=1)
- STRIDE, 1, address increment between consecutive accesses
- PATTERN_BASE, 32'hABCD_0000, pattern base; data(i) = (PATTERN_BASE + i) & DATA_MASK, truncated to DATA_W
- DATA_MASK, 32'hFFFF_FFFC, mask applied to pattern
- TIMEOUT, 1024, watchdog limit in cycles (optional feature only)

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  asynchronous, active-high reset
- basla_i  in  1  start pulse; sampled only in BOSTA or BITTI
- istek_adres_o  out  ADDR_W  request address = i*STRIDE mod 2^ADDR_W
- istek_veri_o  out  DATA_W  write data = data(i); 0 during reads
- istek_gecerli_o  out  1  request valid
- istek_yaz_o  out  1  1 = write, 0 = read
- istek_hazir_i  in  1  slave accepts request
- cevap_veri_i  in  DATA_W  read response data
- cevap_gecerli_i  in  1  response valid
- cevap_hazir_o  out  1  engine ready for response
- bitti_o  out  1  test finished
- basarili_o  out  1  bitti_o and zero errors and no timeout
- hata_sayisi_o  out  32  mismatch count, saturates at 32'hFFFF_FFFF
- ilk_hata_adres_o  out  ADDR_W  address of first mismatch; 0 if none

Behaviour:
- Reset: every output 0, state BOSTA, index i=0, counters 0. Assertion mid-test aborts immediately (async); no partial results kept.
- Transfer rule: request accepted on rising edge with istek_gecerli_o && istek_hazir_i; response consumed on edge with cevap_gecerli_i && cevap_hazir_o. Address/data/yaz stable while gecerli high and not accepted.
- States: BOSTA, YAZ, OKU_ISTEK, OKU_BEKLE, BITTI.
- BOSTA: basla_i=1 -> YAZ next cycle, i=0, error count, first-error address and first-error flag cleared.
- YAZ: gecerli=1, yaz=1. On accept: i==TEST_LEN-1 -> OKU_ISTEK with i=0; else i+1. Back-to-back: gecerli stays high, a new write every cycle if hazir_i held high. Writes expect no response.
- OKU_ISTEK: gecerli=1, yaz=0, cevap_hazir_o=0. On accept -> OKU_BEKLE.
- OKU_BEKLE: gecerli=0, cevap_hazir_o=1. On response: compare cevap_veri_i with data(i); mismatch -> error count +1 (saturating); first mismatch latches address into ilk_hata_adres_o. Then i==TEST_LEN-1 -> BITTI, else OKU_ISTEK with i+1. One read outstanding at a time.
- Response equal to 0 on mismatch detection is counted normally; response data outside OKU_BEKLE is never consumed (cevap_hazir_o=0).
- BITTI: bitti_o=1; basarili_o = (error count==0); outputs held. basla_i=1 -> restart as from BOSTA, bitti_o drops next cycle.
- basla_i ignored in YAZ/OKU_ISTEK/OKU_BEKLE.
- Latency: basla_i edge -> first request valid 1 cycle later; last response edge -> bitti_o 1 cycle later.
- Index counter width clog2(TEST_LEN)+1; address multiply wraps modulo 2^ADDR_W.

Optional Feature:
- Macro BELLEK_SINAYICI_ZAMANASIMI_EN.
- With: watchdog counts consecutive cycles in YAZ/OKU_ISTEK without accept or in OKU_BEKLE without response; reset on every handshake. Reaching TIMEOUT -> BITTI with bitti_o=1, basarili_o=0, extra output zamanasimi_o=1 (0 at reset, cleared on restart).
- Without: no watchdog, no zamanasimi_o port; engine waits indefinitely.

Test Plan:
- TEST_LEN=8, ideal 1-cycle memory, hazir always 1 -> 8 back-to-back writes data 32'hABCD_0000,_0000,_0000,_0000,_0004,...; readback passes; bitti_o=1, basarili_o=1, hata_sayisi_o=0.
- Memory forcing bit0 of address 5 read data -> hata_sayisi_o=1, ilk_hata_adres_o=5, basarili_o=0.
- STRIDE=4, ADDR_W=8, TEST_LEN=80 -> addresses 0,4,...,252,0,... wrap; overwritten aliases cause mismatches at indices 0..15 -> hata_sayisi_o=16, ilk_hata_adres_o=0.
- istek_hazir_i random 30% low, response delay 0-5 cycles -> request fields stable while stalled; pass with TEST_LEN=64.
- rst_i asserted during OKU_BEKLE -> all outputs 0 same cycle; basla_i after release restarts from i=0 and passes.
- With BELLEK_SINAYICI_ZAMANASIMI_EN, TIMEOUT=16, response withheld -> bitti_o=1, zamanasimi_o=1, basarili_o=0 16 cycles after read accept.
